mem_requester: RTL and testbench

- Initiator-side memory port for the multi-cycle MIPS core.
- Accepts one word read or write request from the core, drives the read/write/address/write-data strobes of the asynchronous word memory, and waits a fixed number of cycles to cover the memory's combinational read latency.
- Captures the read word and returns a one-cycle response to the core.
- Checks word alignment and rejects misaligned requests without touching memory.

---
 rtl/mem_if_pkg.sv | 17 +
 rtl/mem_requester.sv | 109 ++++++++++
 tb/tb_mem_requester.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and constants for the core-side memory requester
package mem_if_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RESP,
    ERR
  } state_e;

endpackage

// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - single-outstanding word requester driving an asynchronous memory
module mem_requester
  import mem_if_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int READ_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int              CNT_W    = $clog2(READ_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_WAIT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if ((req_addr[1:0] & WORD_ALIGN_MASK) != 2'b00) begin
            state_d = ERR;
          end else if (req_write) begin
            state_d = WR;
          end else begin
            state_d = RD;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      RD: begin
        mem_read = 1'b1;
        if (cnt_q == '0) begin
          rdata_d = mem_read_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - directed bench for mem_requester with delayed asynchronous memory models
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;

  logic        r2_valid, r2_write;
  logic [31:0] r2_addr, r2_wdata;
  logic        r2_ready, r2_resp_valid, r2_resp_err;
  logic [31:0] r2_rdata;
  logic        r2_mem_read, r2_mem_write;
  logic [31:0] r2_mem_addr, r2_mem_wdata, r2_mem_rdata;

  logic [31:0] mem1 [64];
  logic [31:0] mem2 [64];

  int n_cmp  = 0;
  int n_fail = 0;
  int rd_cyc = 0, wr_cyc = 0, resp_cnt = 0, ovl_cnt = 0;

  always #5 clk = ~clk;

  mem_requester #(.ADDR_W(32), .DATA_W(32), .READ_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  mem_requester #(.ADDR_W(32), .DATA_W(32), .READ_WAIT(1)) dut_fast (
    .clk(clk), .reset(reset),
    .req_valid(r2_valid), .req_write(r2_write), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .req_ready(r2_ready), .resp_valid(r2_resp_valid), .resp_err(r2_resp_err), .resp_rdata(r2_rdata),
    .mem_read(r2_mem_read), .mem_write(r2_mem_write), .mem_addr(r2_mem_addr),
    .mem_write_data(r2_mem_wdata), .mem_read_data(r2_mem_rdata)
  );

  // Slow memory needs more than two cycles; fast memory settles within one.
  assign #25 mem_read_data = mem1[6'(mem_addr >> 2)];
  assign #7  r2_mem_rdata  = mem2[6'(r2_mem_addr >> 2)];

  always @(posedge clk) begin
    if (!reset) begin
      mem1[5] <= 32'hDEADBEEF;
      mem2[5] <= 32'hDEADBEEF;
      mem2[6] <= 32'hCAFEF00D;
    end else begin
      if (mem_write) mem1[6'(mem_addr >> 2)] <= mem_write_data;
      if (r2_mem_write) mem2[6'(r2_mem_addr >> 2)] <= r2_mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (mem_read) rd_cyc++;
    if (mem_write) wr_cyc++;
    if (resp_valid) resp_cnt++;
    if (mem_read && mem_write) ovl_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, resp0, idx, nresp, errs;
    logic [31:0] got [4];
    logic        tw [4];
    logic [31:0] ta [4];
    logic [31:0] td [4];
    tw = '{1'b1, 1'b0, 1'b1, 1'b0};
    ta = '{32'h30, 32'h30, 32'h34, 32'h34};
    td = '{32'hA1A1A1A1, 32'h0, 32'hB2B2B2B2, 32'h0};

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    r2_valid = 1'b0; r2_write = 1'b0; r2_addr = '0; r2_wdata = '0;

    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_fast_ready", r2_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // aligned read of word 5
    rd0 = rd_cyc;
    issue(1'b0, 32'h14, 32'h0);
    check("rd_c1_mem_read", mem_read, 1);
    check("rd_c1_mem_addr", mem_addr, 32'h14);
    check("rd_c1_ready", req_ready, 0);
    @(negedge clk);
    check("rd_c2_mem_read", mem_read, 1);
    @(negedge clk);
    check("rd_c3_mem_read", mem_read, 1);
    check("rd_c3_resp_valid", resp_valid, 0);
    @(negedge clk);
    check("rd_c4_mem_read", mem_read, 0);
    check("rd_c4_resp_valid", resp_valid, 1);
    check("rd_c4_resp_err", resp_err, 0);
    check("rd_c4_rdata", resp_rdata, 32'hDEADBEEF);
    check("rd_strobe_cycles", rd_cyc - rd0, 3);
    @(negedge clk);
    check("rd_c5_resp_valid", resp_valid, 0);
    check("rd_c5_ready", req_ready, 1);

    // write then read back
    wr0 = wr_cyc;
    issue(1'b1, 32'h20, 32'h12345678);
    check("wr_c1_mem_write", mem_write, 1);
    check("wr_c1_mem_read", mem_read, 0);
    check("wr_c1_mem_addr", mem_addr, 32'h20);
    check("wr_c1_mem_wdata", mem_write_data, 32'h12345678);
    check("wr_c1_resp_valid", resp_valid, 0);
    @(negedge clk);
    check("wr_c2_mem_write", mem_write, 0);
    check("wr_c2_resp_valid", resp_valid, 1);
    check("wr_c2_resp_err", resp_err, 0);
    check("wr_c2_rdata_kept", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_c3_ready", req_ready, 1);
    check("wr_strobe_cycles", wr_cyc - wr0, 1);
    issue(1'b0, 32'h20, 32'h0);
    repeat (3) @(negedge clk);
    check("rb_resp_valid", resp_valid, 1);
    check("rb_rdata", resp_rdata, 32'h12345678);
    @(negedge clk);

    // misaligned read
    rd0 = rd_cyc; wr0 = wr_cyc; resp0 = resp_cnt;
    issue(1'b0, 32'h22, 32'h0);
    check("err_c1_resp_valid", resp_valid, 1);
    check("err_c1_resp_err", resp_err, 1);
    check("err_c1_mem_read", mem_read, 0);
    check("err_c1_mem_write", mem_write, 0);
    check("err_c1_rdata_kept", resp_rdata, 32'h12345678);
    @(negedge clk);
    check("err_c2_resp_valid", resp_valid, 0);
    check("err_c2_ready", req_ready, 1);
    check("err_no_reads", rd_cyc - rd0, 0);
    check("err_no_writes", wr_cyc - wr0, 0);
    check("err_one_resp", resp_cnt - resp0, 1);

    // back-to-back with req_valid held high and junk while busy
    rd0 = rd_cyc; wr0 = wr_cyc; resp0 = resp_cnt;
    idx = 0; nresp = 0; errs = 0;
    for (int c = 0; c < 80 && nresp < 4; c++) begin
      if (resp_valid) begin
        if (nresp < 4) got[nresp] = resp_rdata;
        if (resp_err) errs++;
        nresp++;
      end
      if (req_ready && idx < 4) begin
        req_valid = 1'b1; req_write = tw[idx]; req_addr = ta[idx]; req_wdata = td[idx];
        idx++;
      end else if (!req_ready) begin
        req_valid = 1'b1; req_write = 1'b1;
        req_addr  = c[0] ? 32'h3C : 32'h38;
        req_wdata = 32'hFFFFFFFF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; req_write = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_resp_seen", nresp, 4);
    check("b2b_read1", got[1], 32'hA1A1A1A1);
    check("b2b_read2", got[3], 32'hB2B2B2B2);
    check("b2b_no_err", errs, 0);
    check("b2b_resp_total", resp_cnt - resp0, 4);
    check("b2b_write_cycles", wr_cyc - wr0, 2);
    check("b2b_read_cycles", rd_cyc - rd0, 6);
    check("b2b_overlap", ovl_cnt, 0);

    // reset during second RD cycle
    resp0 = resp_cnt;
    issue(1'b0, 32'h14, 32'h0);
    @(negedge clk);
    check("mid_rd_mem_read", mem_read, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_mem_read", mem_read, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_rdata", resp_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_no_resp", resp_cnt - resp0, 0);
    issue(1'b0, 32'h14, 32'h0);
    repeat (3) @(negedge clk);
    check("post_rst_resp_valid", resp_valid, 1);
    check("post_rst_rdata", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // READ_WAIT=1 instance
    r2_valid = 1'b1; r2_write = 1'b0; r2_addr = 32'h18;
    @(negedge clk);
    r2_valid = 1'b0;
    check("fast_c1_mem_read", r2_mem_read, 1);
    check("fast_c1_resp_valid", r2_resp_valid, 0);
    @(negedge clk);
    check("fast_c2_resp_valid", r2_resp_valid, 1);
    check("fast_c2_resp_err", r2_resp_err, 0);
    check("fast_c2_rdata", r2_rdata, 32'hCAFEF00D);
    check("fast_c2_mem_read", r2_mem_read, 0);
    @(negedge clk);
    r2_valid = 1'b1; r2_write = 1'b1; r2_addr = 32'h1C; r2_wdata = 32'h55AA55AA;
    @(negedge clk);
    r2_valid = 1'b0; r2_write = 1'b0;
    check("fast_wr_mem_write", r2_mem_write, 1);
    @(negedge clk);
    check("fast_wr_resp_valid", r2_resp_valid, 1);
    @(negedge clk);
    check("fast_wr_ready", r2_ready, 1);
    r2_valid = 1'b1; r2_addr = 32'h1C;
    @(negedge clk);
    r2_valid = 1'b0;
    @(negedge clk);
    check("fast_rb_rdata", r2_rdata, 32'h55AA55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
